writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage of the 32-bit RISC-V core, sitting directly upstream of the register file. It merges single-cycle ALU results with in-order long-latency load/store-unit (LSU) responses into one registered write port that drives the register file's write enable, address and data inputs. It also keeps a scoreboard of destination registers with outstanding LSU results, so decode can stall on RAW and WAW hazards.

## Interface
- `LSU_DEPTH`, default 4: maximum outstanding LSU operations; power of two, at least 2.
- `clk` in 1: clock; all state updates on the rising edge.
- `arstn` in 1: asynchronous active-low reset.
- `aluValid` in 1: an ALU result is presented.
- `aluReady` out 1: the ALU result is accepted this cycle.
- `aluRd` in 5: ALU destination register.
- `aluData` in 32: ALU result.
- `lsuIssueValid` in 1: the LSU issues an operation that will return a result.
- `lsuIssueReady` out 1: the issue is accepted this cycle.
- `lsuIssueRd` in 5: destination register of the issued operation.
- `lsuRespValid` in 1: the oldest outstanding LSU result is presented. It is always accepted; there is no ready signal.
- `lsuRespData` in 32: LSU result data.
- `readAddr1` in 5, `readAddr2` in 5: decode source register addresses.
- `busy1` out 1, `busy2` out 1: the matching source register must not be read yet.
- `writeEn` out 1, `writeAddr` out 5, `writeData` out 32: registered write port to the register file.
- `pendingCount` out `$clog2(LSU_DEPTH+1)`: number of outstanding LSU operations.
- `protocolErr` out 1: sticky flag; set when a response arrives while nothing is outstanding.

## Operation
- **Pending queue:** FIFO of `LSU_DEPTH` 5-bit rd entries. An accepted issue pushes `lsuIssueRd`; `lsuRespValid` pops the head.
- **Scoreboard:** `pending[31:0]`.
  - An accepted issue with rd≠0 sets `pending[rd]`.
  - A pop clears `pending[head rd]`.
  - `pending[0]` is always 0.
- **LSU issue acceptance:** `lsuIssueReady = !full && !(lsuIssueRd!=0 && pending[lsuIssueRd])`.
  - A pop in the same cycle does not free a slot.
  - A pop in the same cycle does not clear the blocking bit early.
- **ALU acceptance:** `aluReady = !lsuRespValid && !(aluRd!=0 && pending[aluRd])`. LSU responses have priority.
- **Write selection:** the next-cycle write comes from an LSU response if one is present, otherwise from an accepted ALU result, otherwise nothing.
  - `writeEn` is registered as 1 only when the selected rd≠0.
  - A result to x0 is consumed without writing.
  - An rd=0 LSU entry still occupies the queue, preserving response order.
- **Hazard outputs:** `busyN = pending[readAddrN] || (writeEn && writeAddr==readAddrN && readAddrN!=0)`. Both terms are needed because the register file commits one edge after `writeEn` is asserted.
- **Empty-queue response:** a response with an empty queue is ignored (no write, no pop) and sets `protocolErr`, which is cleared only by reset.
- **`pendingCount`:** current queue occupancy, registered.

## Timing
- **Reset:** while `arstn` is low, all outputs and state are 0. This covers `writeEn`, `writeAddr`, `writeData`, `pendingCount`, `protocolErr`, the queue pointers and `pending`. Reset mid-operation discards all outstanding entries.
- **Handshake outputs:** `aluReady` and `lsuIssueReady` are combinational from the inputs and registered state. `busy1` and `busy2` are combinational from `readAddrN` and registered state.
- **Write latency:** an accepted ALU result or LSU response appears on `writeEn`/`writeAddr`/`writeData` exactly 1 cycle later. The register file holds the value at the following edge.
- **Scoreboard timing:** the pending bit set by an issue is visible on `busyN` the cycle after acceptance. At the response edge, the pending bit clears and `writeEn` rises, so `busyN` stays high for exactly one further cycle through the in-flight term.
- **Issue and response in the same cycle:** both take effect. Occupancy is unchanged, with no overflow or underflow. Pointers wrap modulo `LSU_DEPTH`.
- **Idle cycles:** when no write is selected, `writeEn`=0. `writeAddr` and `writeData` hold their previous values.

## Configuration
- **`WB_FWD_EN` defined:** adds ports `fwdValid1`/`fwdValid2` (out 1) and `fwdData1`/`fwdData2` (out 32).
  - `fwdValidN = writeEn && writeAddr==readAddrN && readAddrN!=0`.
  - `fwdDataN = writeData`.
  - The in-flight term is removed from `busyN`, which then depends only on `pending[readAddrN]`.
- **`WB_FWD_EN` undefined:** the forwarding ports are absent and `busyN` includes the in-flight term as specified above.

## Test plan
- **Reset mid-queue:** issue x5, x6, x7, then pulse `arstn` low.
  - Required: all outputs read 0 and `busy` is 0 for x5, x6 and x7.
  - A subsequent response sets `protocolErr`.
- **ALU path:** `aluValid`, `aluRd`=3, `aluData`=0xDEADBEEF at cycle N.
  - Required: `writeEn`=1, `writeAddr`=3, `writeData`=0xDEADBEEF at cycle N+1.
  - Required: `busy1`=1 with `readAddr1`=3 during cycle N+1 only.
- **Ordering and x0:** issue rd=4, rd=0, rd=9, then respond with 0x11, 0x22, 0x33.
  - Required: writes (4, 0x11) and then (9, 0x33); no write for the 0x22 response.
  - Required: `pendingCount` steps 1, 2, 3, 2, 1, 0.
- **Full queue:** issue `LSU_DEPTH`=4 operations to distinct rd.
  - Required: `lsuIssueReady`=0 on the fifth, even when a response arrives in the same cycle.
  - Required: the fifth is accepted the following cycle.
- **Hazard stalls:** with x8 pending, present an ALU result and an LSU issue both to x8.
  - Required: both are stalled.
  - Required: an `lsuRespValid` cycle forces `aluReady`=0 for `aluRd`=12.
- **Forwarding:** with `WB_FWD_EN`, an ALU write to x10 of 0x55 and `readAddr2`=10 one cycle later.
  - Required: `fwdValid2`=1, `fwdData2`=0x55, `busy2`=0.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and in-order LSU responses into one registered
// register-file write port, and keeps a scoreboard of LSU-pending destinations.
// Optional macro WB_FWD_EN adds forwarding ports and drops the in-flight term from busy.
module writeback_unit #(
  parameter int LSU_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           aluValid,
  output logic                           aluReady,
  input  logic [4:0]                     aluRd,
  input  logic [31:0]                    aluData,
  input  logic                           lsuIssueValid,
  output logic                           lsuIssueReady,
  input  logic [4:0]                     lsuIssueRd,
  input  logic                           lsuRespValid,
  input  logic [31:0]                    lsuRespData,
  input  logic [4:0]                     readAddr1,
  input  logic [4:0]                     readAddr2,
  output logic                           busy1,
  output logic                           busy2,
  output logic                           writeEn,
  output logic [4:0]                     writeAddr,
  output logic [31:0]                    writeData,
  output logic [$clog2(LSU_DEPTH+1)-1:0] pendingCount,
  output logic                           protocolErr
`ifdef WB_FWD_EN
  ,
  output logic                           fwdValid1,
  output logic                           fwdValid2,
  output logic [31:0]                    fwdData1,
  output logic [31:0]                    fwdData2
`endif
);

  localparam int AW = $clog2(LSU_DEPTH);
  localparam int CW = $clog2(LSU_DEPTH + 1);

  logic [4:0]    rd_q [LSU_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;

  logic          q_full;
  logic          q_empty;
  logic          push;
  logic          pop;
  logic          bad_resp;
  logic [4:0]    head_rd;
  logic          alu_acc;

  logic          sel_vld_p0;
  logic [4:0]    sel_rd_p0;
  logic [31:0]   sel_data_p0;

  logic          hit1;
  logic          hit2;

  assign q_full   = (count == CW'(LSU_DEPTH));
  assign q_empty  = (count == '0);
  assign head_rd  = rd_q[head];

  // Readiness looks only at registered state: a same-cycle pop frees nothing early.
  assign lsuIssueReady = !q_full && !(lsuIssueRd != 5'd0 && pending[lsuIssueRd]);
  assign aluReady      = !lsuRespValid && !(aluRd != 5'd0 && pending[aluRd]);

  assign push     = lsuIssueValid && lsuIssueReady;
  assign pop      = lsuRespValid && !q_empty;
  assign bad_resp = lsuRespValid && q_empty;
  assign alu_acc  = aluValid && aluReady;

  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_rd_p0   = 5'd0;
    sel_data_p0 = 32'd0;
    if (pop) begin
      sel_vld_p0  = 1'b1;
      sel_rd_p0   = head_rd;
      sel_data_p0 = lsuRespData;
    end else if (alu_acc) begin
      sel_vld_p0  = 1'b1;
      sel_rd_p0   = aluRd;
      sel_data_p0 = aluData;
    end
  end

  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_rd] = 1'b0;
    if (push && lsuIssueRd != 5'd0) pending_nxt[lsuIssueRd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // p0 -> p1: queue, scoreboard and the registered write port
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < LSU_DEPTH; i++) rd_q[i] <= 5'd0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      pending      <= 32'd0;
      writeEn      <= 1'b0;
      writeAddr    <= 5'd0;
      writeData    <= 32'd0;
      protocolErr  <= 1'b0;
    end else begin
      if (push) begin
        rd_q[tail] <= lsuIssueRd;
        tail       <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      pending <= pending_nxt;
      writeEn <= sel_vld_p0 && (sel_rd_p0 != 5'd0);
      if (sel_vld_p0 && sel_rd_p0 != 5'd0) begin
        writeAddr <= sel_rd_p0;
        writeData <= sel_data_p0;
      end
      if (bad_resp) protocolErr <= 1'b1;
    end
  end

  assign pendingCount = count;

  assign hit1 = writeEn && (writeAddr == readAddr1) && (readAddr1 != 5'd0);
  assign hit2 = writeEn && (writeAddr == readAddr2) && (readAddr2 != 5'd0);

`ifdef WB_FWD_EN
  assign fwdValid1 = hit1;
  assign fwdValid2 = hit2;
  assign fwdData1  = writeData;
  assign fwdData2  = writeData;
  assign busy1     = pending[readAddr1];
  assign busy2     = pending[readAddr2];
`else
  // The register file commits one edge after writeEn, so the in-flight write still blocks reads.
  assign busy1 = pending[readAddr1] || hit1;
  assign busy2 = pending[readAddr2] || hit2;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model with a per-cycle compare process,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_unit;

  localparam int LSU_DEPTH = 4;
  localparam int CW = $clog2(LSU_DEPTH + 1);

  logic          clk = 1'b0;
  logic          arstn;
  logic          aluValid, aluReady;
  logic [4:0]    aluRd;
  logic [31:0]   aluData;
  logic          lsuIssueValid, lsuIssueReady;
  logic [4:0]    lsuIssueRd;
  logic          lsuRespValid;
  logic [31:0]   lsuRespData;
  logic [4:0]    readAddr1, readAddr2;
  logic          busy1, busy2;
  logic          writeEn;
  logic [4:0]    writeAddr;
  logic [31:0]   writeData;
  logic [CW-1:0] pendingCount;
  logic          protocolErr;
`ifdef WB_FWD_EN
  logic          fwdValid1, fwdValid2;
  logic [31:0]   fwdData1, fwdData2;
`endif

  writeback_unit #(.LSU_DEPTH(LSU_DEPTH)) dut (
    .clk(clk), .arstn(arstn),
    .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
    .lsuIssueValid(lsuIssueValid), .lsuIssueReady(lsuIssueReady), .lsuIssueRd(lsuIssueRd),
    .lsuRespValid(lsuRespValid), .lsuRespData(lsuRespData),
    .readAddr1(readAddr1), .readAddr2(readAddr2), .busy1(busy1), .busy2(busy2),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .pendingCount(pendingCount), .protocolErr(protocolErr)
`ifdef WB_FWD_EN
    , .fwdValid1(fwdValid1), .fwdValid2(fwdValid2), .fwdData1(fwdData1), .fwdData2(fwdData2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding LSU destinations kept as a plain ordered list.
  logic [4:0]  mq[$];
  bit          m_we  = 0;
  logic [4:0]  m_wa  = '0;
  logic [31:0] m_wd  = '0;
  bit          m_err = 0;

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit inflight(input logic [4:0] r);
    return m_we && (m_wa == r) && (r != 5'd0);
  endfunction

  always @(posedge clk or negedge arstn) begin : model
    bit ir, ar;
    logic [4:0] h;
    if (!arstn) begin
      mq.delete();
      m_we = 0; m_wa = '0; m_wd = '0; m_err = 0;
    end else begin
      ir = (mq.size() < LSU_DEPTH) && !pend(lsuIssueRd);
      ar = !lsuRespValid && !pend(aluRd);
      m_we = 0;
      if (lsuRespValid) begin
        if (mq.size() == 0) m_err = 1;
        else begin
          h = mq.pop_front();
          if (h != 5'd0) begin m_we = 1; m_wa = h; m_wd = lsuRespData; end
        end
      end else if (aluValid && ar && aluRd != 5'd0) begin
        m_we = 1; m_wa = aluRd; m_wd = aluData;
      end
      if (lsuIssueValid && ir) mq.push_back(lsuIssueRd);
    end
  end

  always @(negedge clk) begin : compare
    chk("writeEn", writeEn, m_we);
    if (m_we) begin
      chk("writeAddr", writeAddr, m_wa);
      chk("writeData", writeData, m_wd);
    end
    chk("pendingCount", pendingCount, mq.size());
    chk("protocolErr", protocolErr, m_err);
    chk("aluReady", aluReady, !lsuRespValid && !pend(aluRd));
    chk("lsuIssueReady", lsuIssueReady, (mq.size() < LSU_DEPTH) && !pend(lsuIssueRd));
`ifdef WB_FWD_EN
    chk("busy1", busy1, pend(readAddr1));
    chk("busy2", busy2, pend(readAddr2));
    chk("fwdValid1", fwdValid1, inflight(readAddr1));
    chk("fwdValid2", fwdValid2, inflight(readAddr2));
    if (m_we) chk("fwdData1", fwdData1, m_wd);
`else
    chk("busy1", busy1, pend(readAddr1) || inflight(readAddr1));
    chk("busy2", busy2, pend(readAddr2) || inflight(readAddr2));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arstn = 1'b0;
    aluValid = 0; aluRd = '0; aluData = '0;
    lsuIssueValid = 0; lsuIssueRd = '0;
    lsuRespValid = 0; lsuRespData = '0;
    readAddr1 = '0; readAddr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_writeEn", writeEn, 0);
    chk("rst_writeAddr", writeAddr, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_pendingCount", pendingCount, 0);
    chk("rst_protocolErr", protocolErr, 0);
    arstn = 1'b1;
    tick();

    // ALU path
    aluValid = 1; aluRd = 5'd3; aluData = 32'hDEADBEEF; readAddr1 = 5'd3;
    #1 chk("alu_busy1_N", busy1, 0);
    chk("alu_ready_N", aluReady, 1);
    tick();
    aluValid = 0;
    #1 chk("alu_we_N1", writeEn, 1);
    chk("alu_wa_N1", writeAddr, 3);
    chk("alu_wd_N1", writeData, 32'hDEADBEEF);
    chk("alu_busy1_N1", busy1, 1);
    tick();
    #1 chk("alu_busy1_N2", busy1, 0);
    chk("alu_we_N2", writeEn, 0);
    chk("alu_wd_hold", writeData, 32'hDEADBEEF);
    readAddr1 = '0;

    // Ordering and x0
    lsuIssueValid = 1; lsuIssueRd = 5'd4; tick();
    #1 chk("ord_cnt1", pendingCount, 1);
    lsuIssueRd = 5'd0; tick();
    #1 chk("ord_cnt2", pendingCount, 2);
    lsuIssueRd = 5'd9; tick();
    #1 chk("ord_cnt3", pendingCount, 3);
    lsuIssueValid = 0;
    lsuRespValid = 1; lsuRespData = 32'h11; tick();
    #1 chk("ord_we1", writeEn, 1);
    chk("ord_wa1", writeAddr, 4);
    chk("ord_wd1", writeData, 32'h11);
    chk("ord_cnt4", pendingCount, 2);
    lsuRespData = 32'h22; tick();
    #1 chk("ord_we2", writeEn, 0);
    chk("ord_cnt5", pendingCount, 1);
    lsuRespData = 32'h33; tick();
    #1 chk("ord_we3", writeEn, 1);
    chk("ord_wa3", writeAddr, 9);
    chk("ord_wd3", writeData, 32'h33);
    chk("ord_cnt6", pendingCount, 0);
    lsuRespValid = 0;

    // Full queue
    lsuIssueValid = 1;
    for (int r = 1; r <= LSU_DEPTH; r++) begin
      lsuIssueRd = 5'(r);
      tick();
    end
    #1 chk("full_cnt", pendingCount, LSU_DEPTH);
    lsuIssueRd = 5'd5; lsuRespValid = 1; lsuRespData = 32'hA1;
    #1 chk("full_ready_with_resp", lsuIssueReady, 0);
    tick();
    lsuRespValid = 0;
    #1 chk("full_ready_next", lsuIssueReady, 1);
    tick();
    lsuIssueValid = 0;
    #1 chk("full_cnt_after", pendingCount, LSU_DEPTH);
    lsuRespValid = 1;
    repeat (LSU_DEPTH) tick();
    lsuRespValid = 0;
    #1 chk("full_drained", pendingCount, 0);

    // Hazard stalls
    lsuIssueValid = 1; lsuIssueRd = 5'd8; tick();
    aluValid = 1; aluRd = 5'd8; aluData = 32'h77;
    #1 chk("haz_alu_stall", aluReady, 0);
    chk("haz_issue_stall", lsuIssueReady, 0);
    tick();
    lsuIssueValid = 0; aluRd = 5'd12; lsuRespValid = 1; lsuRespData = 32'h88;
    #1 chk("haz_resp_prio", aluReady, 0);
    tick();
    lsuRespValid = 0; readAddr1 = 5'd8;
    #1 chk("haz_alu_free", aluReady, 1);
`ifndef WB_FWD_EN
    chk("haz_busy_inflight", busy1, 1);
`endif
    tick();
    aluValid = 0; readAddr1 = '0;

`ifdef WB_FWD_EN
    aluValid = 1; aluRd = 5'd10; aluData = 32'h55; tick();
    aluValid = 0; readAddr2 = 5'd10;
    #1 chk("fwd_valid2", fwdValid2, 1);
    chk("fwd_data2", fwdData2, 32'h55);
    chk("fwd_busy2", busy2, 0);
    tick();
    readAddr2 = '0;
`endif

    // Reset mid-queue
    lsuIssueValid = 1;
    lsuIssueRd = 5'd5; tick();
    lsuIssueRd = 5'd6; tick();
    lsuIssueRd = 5'd7; tick();
    lsuIssueValid = 0; readAddr1 = 5'd5; readAddr2 = 5'd6;
    #1 chk("mid_busy_before", busy1, 1);
    arstn = 0;
    #1 chk("mid_we", writeEn, 0);
    chk("mid_wa", writeAddr, 0);
    chk("mid_wd", writeData, 0);
    chk("mid_cnt", pendingCount, 0);
    chk("mid_busy1", busy1, 0);
    chk("mid_busy2", busy2, 0);
    readAddr1 = 5'd7;
    #1 chk("mid_busy7", busy1, 0);
    tick();
    arstn = 1; readAddr1 = '0; readAddr2 = '0;
    lsuRespValid = 1; lsuRespData = 32'hBAD;
    tick();
    lsuRespValid = 0;
    #1 chk("mid_protocolErr", protocolErr, 1);
    chk("mid_no_write", writeEn, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      aluValid      = 1'($urandom_range(0, 1));
      aluRd         = 5'($urandom_range(0, 7));
      aluData       = $urandom;
      lsuIssueValid = 1'($urandom_range(0, 1));
      lsuIssueRd    = 5'($urandom_range(0, 7));
      lsuRespValid  = ($urandom_range(0, 2) == 0);
      lsuRespData   = $urandom;
      readAddr1     = 5'($urandom_range(0, 7));
      readAddr2     = 5'($urandom_range(0, 7));
      tick();
    end
    aluValid = 0; lsuIssueValid = 0; lsuRespValid = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
